// File: rtl/dmem_byte_sequencer.sv
// Byte-serialising load/store front end for the banked data memory.
// Splits byte/half/word requests into single-byte DMEM cycles and reassembles loads.
module dmem_byte_sequencer #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [DATA_W-1:0] dmem_data_in,
  output logic [ADDR_W-1:0] dmem_address,
  output logic              dmem_read_write,
  input  logic [7:0]        dmem_dataOut
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    DRAIN,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        cnt_q, cap_q, size_q;
  logic [1:0]        last_idx, cnt_nxt;
  logic              sign_q;
  logic [DATA_W-1:0] wdata_q, asm_q, asm_d;
  logic [RD_LAT-1:0] pipe_q;

  logic accept, req_bad, at_last;
  logic capture, cap_last;

  logic [ADDR_W-1:0] addr_d;
  logic              rw_d, rv_d, err_d;
  logic [DATA_W-1:0] din_d, rdata_d;

  function automatic logic [1:0] last_of(input logic [1:0] sz);
    logic [1:0] r;
    unique case (sz)
      2'd0:    r = 2'd0;
      2'd1:    r = 2'd1;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] extend(
    input logic [DATA_W-1:0] a,
    input logic [1:0]        sz,
    input logic              sg
  );
    logic [DATA_W-1:0] r;
    unique case (sz)
      2'd0:    r = {{(DATA_W-8){sg & a[7]}}, a[7:0]};
      2'd1:    r = {{(DATA_W-16){sg & a[15]}}, a[15:0]};
      default: r = a;
    endcase
    return r;
  endfunction

  assign req_bad = (req_size == 2'd3)
                 | ((req_size == 2'd1) & req_addr[0])
                 | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;
  assign last_idx  = last_of(size_q);
  assign at_last   = (cnt_q == last_idx);
  assign cnt_nxt   = cnt_q + 2'd1;

  // A read byte appears RD_LAT cycles after its address cycle
  assign capture  = pipe_q[RD_LAT-1];
  assign cap_last = capture & (cap_q == last_idx);

  always_comb begin
    asm_d = asm_q;
    if (capture)
      asm_d = asm_q | (DATA_W'(dmem_dataOut) << {cap_q, 3'b000});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_bad)        state_d = RESP;
          else if (req_write) state_d = WRITE;
          else                state_d = READ;
        end
      end
      READ:    if (at_last)  state_d = DRAIN;
      WRITE:   if (at_last)  state_d = RESP;
      DRAIN:   if (cap_last) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d  = dmem_address;
    rw_d    = 1'b0;
    din_d   = '0;
    rv_d    = 1'b0;
    err_d   = resp_err;
    rdata_d = resp_rdata;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          err_d   = 1'b0;
          rdata_d = '0;
          if (req_bad) begin
            rv_d  = 1'b1;
            err_d = 1'b1;
          end else begin
            addr_d = req_addr;
            if (req_write) begin
              rw_d  = 1'b1;
              din_d = DATA_W'(req_wdata[7:0]);
            end
          end
        end
      end
      READ: begin
        if (!at_last)
          addr_d = dmem_address + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      WRITE: begin
        if (!at_last) begin
          addr_d = dmem_address + {{(ADDR_W-1){1'b0}}, 1'b1};
          rw_d   = 1'b1;
          din_d  = DATA_W'(wdata_q[{cnt_nxt, 3'b000} +: 8]);
        end else begin
          rv_d = 1'b1;
        end
      end
      DRAIN: begin
        if (cap_last) begin
          rv_d    = 1'b1;
          rdata_d = extend(asm_d, size_q, sign_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem_address    <= '0;
      dmem_read_write <= 1'b0;
      dmem_data_in    <= '0;
      resp_valid      <= 1'b0;
      resp_err        <= 1'b0;
      resp_rdata      <= '0;
    end else begin
      dmem_address    <= addr_d;
      dmem_read_write <= rw_d;
      dmem_data_in    <= din_d;
      resp_valid      <= rv_d;
      resp_err        <= err_d;
      resp_rdata      <= rdata_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      cap_q   <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      wdata_q <= '0;
      asm_q   <= '0;
      pipe_q  <= '0;
    end else begin
      pipe_q[0] <= (state_q == READ);
      for (int i = 1; i < RD_LAT; i++)
        pipe_q[i] <= pipe_q[i-1];
      if (accept) begin
        cnt_q   <= '0;
        cap_q   <= '0;
        asm_q   <= '0;
        size_q  <= req_size;
        sign_q  <= req_signed;
        wdata_q <= req_wdata;
      end else begin
        if ((state_q == READ || state_q == WRITE) && !at_last)
          cnt_q <= cnt_nxt;
        if (capture) begin
          cap_q <= cap_q + 2'd1;
          asm_q <= asm_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_byte_sequencer.sv
// Directed bench: two sequencers (RD_LAT 1 and 3) share stimulus,
// each with its own byte memory model.
module tb_dmem_byte_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [12:0] req_addr;
  logic [31:0] req_wdata;

  logic        rdy1, rv1, err1, rw1;
  logic [31:0] rd1, din1;
  logic [12:0] a1;
  logic [7:0]  q1;

  logic        rdy3, rv3, err3, rw3;
  logic [31:0] rd3, din3;
  logic [12:0] a3;
  logic [7:0]  q3a, q3b, q3c;

  always #5 clk = ~clk;

  dmem_byte_sequencer #(.ADDR_W(13), .DATA_W(32), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(rdy1),
    .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1),
    .dmem_data_in(din1), .dmem_address(a1),
    .dmem_read_write(rw1), .dmem_dataOut(q1)
  );

  dmem_byte_sequencer #(.ADDR_W(13), .DATA_W(32), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(rdy3),
    .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(rv3), .resp_rdata(rd3), .resp_err(err3),
    .dmem_data_in(din3), .dmem_address(a3),
    .dmem_read_write(rw3), .dmem_dataOut(q3c)
  );

  logic [7:0]  mem1 [0:8191];
  logic [7:0]  mem3 [0:8191];
  int          wcnt1 = 0, wcnt3 = 0;
  logic [12:0] wlast1, wlast3;

  always @(posedge clk) begin
    if (rw1) begin
      mem1[a1] <= din1[7:0];
      wcnt1    <= wcnt1 + 1;
      wlast1   <= a1;
    end
    q1 <= mem1[a1];
  end

  always @(posedge clk) begin
    if (rw3) begin
      mem3[a3] <= din3[7:0];
      wcnt3    <= wcnt3 + 1;
      wlast3   <= a3;
    end
    q3a <= mem3[a3];
    q3b <= q3a;
    q3c <= q3b;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [12:0] addr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
    int          l1;
    int          l3;
  } vec_t;

  vec_t v [16];

  logic [12:0] tr_addr [0:15];
  logic        tr_rw   [0:15];
  logic [31:0] tr_din  [0:15];

  int          l1, l3;
  logic        e1, e3;
  logic [31:0] r1, r3;

  // Entered one tick after an accept edge has been scheduled; waits for both responses
  task automatic wait_resp();
    @(posedge clk); #1;
    req_valid = 1'b0;
    l1 = 0; l3 = 0;
    e1 = 1'b0; e3 = 1'b0;
    r1 = '0; r3 = '0;
    for (int c = 1; c <= 30; c++) begin
      if (c < 16) begin
        tr_addr[c] = a1;
        tr_rw[c]   = rw1;
        tr_din[c]  = din1;
      end
      if (rv1 && l1 == 0) begin
        l1 = c; e1 = err1; r1 = rd1;
      end
      if (rv3 && l3 == 0) begin
        l3 = c; e3 = err3; r3 = rd3;
      end
      @(posedge clk); #1;
      if (l1 != 0 && l3 != 0) break;
    end
  endtask

  task automatic drive(input vec_t t);
    req_valid  = 1'b1;
    req_write  = t.wr;
    req_size   = t.sz;
    req_signed = t.sg;
    req_addr   = t.addr;
    req_wdata  = t.wd;
  endtask

  initial begin
    int   wc1, wc3, rdy_c, sw_c, rv_seen;
    vec_t t;

    v[0]  = '{1'b1, 2'd2, 1'b0, 13'h0010, 32'hA1B2C3D4, 1'b0, 32'h0, 5, 5};
    v[1]  = '{1'b0, 2'd2, 1'b0, 13'h0010, 32'h0, 1'b0, 32'hA1B2C3D4, 6, 8};
    v[2]  = '{1'b0, 2'd0, 1'b1, 13'h0013, 32'h0, 1'b0, 32'hFFFFFFA1, 3, 5};
    v[3]  = '{1'b0, 2'd0, 1'b0, 13'h0013, 32'h0, 1'b0, 32'h000000A1, 3, 5};
    v[4]  = '{1'b0, 2'd1, 1'b1, 13'h0012, 32'h0, 1'b0, 32'hFFFFA1B2, 4, 6};
    v[5]  = '{1'b0, 2'd1, 1'b0, 13'h0012, 32'h0, 1'b0, 32'h0000A1B2, 4, 6};
    v[6]  = '{1'b0, 2'd2, 1'b0, 13'h1FFE, 32'h0, 1'b1, 32'h0, 1, 1};
    v[7]  = '{1'b0, 2'd3, 1'b0, 13'h0010, 32'h0, 1'b1, 32'h0, 1, 1};
    v[8]  = '{1'b1, 2'd1, 1'b0, 13'h0020, 32'hDEAD7F85, 1'b0, 32'h0, 3, 3};
    v[9]  = '{1'b0, 2'd1, 1'b1, 13'h0020, 32'h0, 1'b0, 32'h00007F85, 4, 6};
    v[10] = '{1'b0, 2'd0, 1'b1, 13'h0020, 32'h0, 1'b0, 32'hFFFFFF85, 3, 5};
    v[11] = '{1'b0, 2'd0, 1'b1, 13'h0021, 32'h0, 1'b0, 32'h0000007F, 3, 5};
    v[12] = '{1'b1, 2'd1, 1'b0, 13'h0021, 32'h55667788, 1'b1, 32'h0, 1, 1};
    v[13] = '{1'b1, 2'd0, 1'b0, 13'h1FFF, 32'h12345699, 1'b0, 32'h0, 2, 2};
    v[14] = '{1'b0, 2'd0, 1'b0, 13'h1FFF, 32'h0, 1'b0, 32'h00000099, 3, 5};
    v[15] = '{1'b1, 2'd3, 1'b0, 13'h0040, 32'hFFFFFFFF, 1'b1, 32'h0, 1, 1};

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", {rdy1, rdy3}, 2'b11);
    check("reset resp", {rv1, err1, rv3, err3}, 4'b0);
    check("reset rdata", rd1 | rd3, 32'h0);
    check("reset dmem", {a1, rw1, din1}, 46'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      wc1 = wcnt1; wc3 = wcnt3;
      drive(v[i]);
      wait_resp();
      check($sformatf("v%0d lat rd1", i), l1, v[i].l1);
      check($sformatf("v%0d lat rd3", i), l3, v[i].l3);
      check($sformatf("v%0d err rd1", i), e1, v[i].err);
      check($sformatf("v%0d err rd3", i), e3, v[i].err);
      check($sformatf("v%0d rdata rd1", i), r1, v[i].rd);
      check($sformatf("v%0d rdata rd3", i), r3, v[i].rd);
      check($sformatf("v%0d ready", i), {rdy1, rdy3}, 2'b11);
      if (v[i].err)
        check($sformatf("v%0d no write", i), (wcnt1 - wc1) + (wcnt3 - wc3), 0);
      if (i == 0) begin
        for (int k = 1; k <= 4; k++) begin
          check($sformatf("sw addr c%0d", k), tr_addr[k], 13'h0010 + 13'(k - 1));
          check($sformatf("sw rw c%0d", k), tr_rw[k], 1'b1);
          check($sformatf("sw mem1 b%0d", k - 1), mem1[13'h0010 + 13'(k - 1)],
                v[0].wd[8*(k-1) +: 8]);
          check($sformatf("sw mem3 b%0d", k - 1), mem3[13'h0010 + 13'(k - 1)],
                v[0].wd[8*(k-1) +: 8]);
        end
        check("sw din c1", tr_din[1], 32'h000000D4);
        check("sw din c4", tr_din[4], 32'h000000A1);
        check("sw rw c5", tr_rw[5], 1'b0);
        check("sw din c5", tr_din[5], 32'h0);
      end
      if (i == 1) begin
        for (int k = 1; k <= 4; k++) begin
          check($sformatf("lw addr c%0d", k), tr_addr[k], 13'h0010 + 13'(k - 1));
          check($sformatf("lw rw c%0d", k), tr_rw[k], 1'b0);
        end
        check("lw drain addr", tr_addr[5], 13'h0013);
      end
    end

    // Back-to-back: valid held high, fields change while busy
    t = '{1'b1, 2'd2, 1'b0, 13'h0030, 32'h11223344, 1'b0, 32'h0, 5, 5};
    drive(t);
    @(posedge clk); #1;
    t = '{1'b0, 2'd2, 1'b0, 13'h0030, 32'h0, 1'b0, 32'h11223344, 6, 8};
    drive(t);
    rdy_c = 0; sw_c = 0;
    for (int c = 1; c <= 20; c++) begin
      if (rv1 && sw_c == 0) sw_c = c;
      if (rdy1) begin
        rdy_c = c;
        break;
      end
      @(posedge clk); #1;
    end
    check("b2b sw resp", sw_c, 5);
    check("b2b ready cycle", rdy_c, 6);
    check("b2b ready rd3", rdy3, 1'b1);
    wait_resp();
    check("b2b lw lat rd1", l1, 6);
    check("b2b lw lat rd3", l3, 8);
    check("b2b lw rdata rd1", r1, 32'h11223344);
    check("b2b lw rdata rd3", r3, 32'h11223344);

    // Reset in cycle 2 of a word store at the top of memory
    wc1 = wcnt1; wc3 = wcnt3;
    t = '{1'b1, 2'd2, 1'b0, 13'h1FFC, 32'hCAFEBABE, 1'b0, 32'h0, 5, 5};
    drive(t);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort ready", {rdy1, rdy3}, 2'b11);
    check("abort resp", {rv1, err1, rv3, err3}, 4'b0);
    check("abort dmem", {a1, rw1, din1}, 46'h0);
    check("abort dmem rd3", {a3, rw3, din3}, 46'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rv_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (rv1 || rv3) rv_seen++;
    end
    check("abort no resp", rv_seen, 0);
    check("abort ready after", {rdy1, rdy3}, 2'b11);
    check("abort writes rd1", wcnt1 - wc1, 1);
    check("abort writes rd3", wcnt3 - wc3, 1);
    check("abort waddr", {wlast1, wlast3}, {13'h1FFC, 13'h1FFC});
    check("abort wbyte", mem1[13'h1FFC], 8'hBE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
